uart_rx_param: RTL

//  Parametrised oversampling UART receiver, successor to the fixed 8-bit Rx.

---
 rtl/uart_rx_param.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 3-sample majority vote, false-start reject, 1/2 stop bits,
// framing/overrun flags, valid/ready output. Optional parity when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned OVS         = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic              tick_i,
    input  logic [3:0]        cfg_nbits_i,
    input  logic              cfg_stop2_i,
`ifdef UART_RX_PARITY_EN
    input  logic              cfg_par_en_i,
    input  logic              cfg_par_odd_i,
    output logic              parity_err_o,
`endif
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int unsigned CntW = $clog2(OVS);
    localparam logic [CntW-1:0] CntS0  = CntW'(OVS / 2 - 1);
    localparam logic [CntW-1:0] CntS1  = CntW'(OVS / 2);
    localparam logic [CntW-1:0] CntV   = CntW'(OVS / 2 + 1);
    localparam logic [CntW-1:0] CntEnd = CntW'(OVS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [1:0]          samp_q, samp_d;
    logic [3:0]          bit_q, bit_d;
    logic [3:0]          nbits_q, nbits_d;
    logic                stop2_q, stop2_d;
    logic                stop_idx_q, stop_idx_d;
    logic                armed_q, armed_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                ferr_q, ferr_d;
    logic                commit_q, commit_d;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_valid_q, frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
    logic                par_en_q, par_en_d, par_odd_q, par_odd_d, perr_q, perr_d;
    logic                parity_err_q;
`endif

    logic       rx_s, vote, at_vote, at_end;
    logic [3:0] nb_clamp;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign at_vote  = tick_i && (cnt_q == CntV);
    assign at_end   = tick_i && (cnt_q == CntEnd);
    assign nb_clamp = (cfg_nbits_i < 4'd5 || cfg_nbits_i > 4'(DATA_W)) ? 4'(DATA_W) : cfg_nbits_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        nbits_d    = nbits_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        armed_d    = armed_q;
        shreg_d    = shreg_q;
        ferr_d     = ferr_q;
        commit_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        perr_d     = perr_q;
`endif
        // The third vote sample is taken live from rx_s at CntV.
        if (tick_i && state_q != StIdle) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntS0) samp_d[0] = rx_s;
            if (cnt_q == CntS1) samp_d[1] = rx_s;
        end
        unique case (state_q)
            StIdle: begin
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end
            end
            StStart: begin
                if (at_vote) begin
                    if (vote) begin
                        state_d = StIdle;
                    end else begin
                        nbits_d = nb_clamp;
                        stop2_d = cfg_stop2_i;
                        shreg_d = '0;
                        ferr_d  = 1'b0;
                        bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                        par_en_d  = cfg_par_en_i;
                        par_odd_d = cfg_par_odd_i;
                        perr_d    = 1'b0;
`endif
                    end
                end
                if (at_end) state_d = StData;
            end
            StData: begin
                if (at_vote) begin
                    for (int i = 0; i < int'(DATA_W); i++) begin
                        if (bit_q == 4'(i)) shreg_d[i] = vote;
                    end
                end
                if (at_end) begin
                    if (bit_q == nbits_q - 4'd1) begin
                        stop_idx_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        state_d = par_en_q ? StParity : StStop;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (at_vote) perr_d = vote ^ (^shreg_q) ^ par_odd_q;
                if (at_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (at_vote) begin
                    if (!vote) ferr_d = 1'b1;
                    // Commit half a bit early so the next start edge can resync.
                    if (stop_idx_q == stop2_q) begin
                        commit_d = 1'b1;
                        state_d  = StIdle;
                    end
                end
                if (at_end) stop_idx_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            sync_q     <= '1;
            cnt_q      <= '0;
            samp_q     <= '0;
            bit_q      <= '0;
            nbits_q    <= 4'(DATA_W);
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            armed_q    <= 1'b0;
            shreg_q    <= '0;
            ferr_q     <= 1'b0;
            commit_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_i};
            cnt_q      <= cnt_d;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            nbits_q    <= nbits_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            armed_q    <= armed_d;
            shreg_q    <= shreg_d;
            ferr_q     <= ferr_d;
            commit_q   <= commit_d;
`ifdef UART_RX_PARITY_EN
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            perr_q     <= perr_d;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            overrun_q <= 1'b0;
            if (commit_q) begin
                if (!rx_valid_q || rx_ready_i) begin
                    rx_data_q    <= shreg_q;
                    rx_valid_q   <= 1'b1;
                    frame_err_q  <= ferr_q;
`ifdef UART_RX_PARITY_EN
                    parity_err_q <= perr_q;
`endif
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`endif

endmodule
